// File: rtl/systolic_output_queue.sv
// Collects N results per column from a systolic array into an N*N row-major buffer; optional idle watchdog under SYSTOLIC_OQ_TIMEOUT_EN.
// Latency: a column write lands on the next edge; host reads return registered data one cycle after rd_en_i.
// Backpressure: none -- producers are never stalled; words arriving on a full column are dropped and flagged in overflow_o.
module systolic_output_queue #(
    parameter int N              = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic [N-1:0][DATA_WIDTH-1:0]     col_data_i,
    input  logic [N-1:0]                     col_valid_i,
    input  logic                             rd_en_i,
    input  logic [$clog2(N*N)-1:0]           rd_addr_i,
    output logic [DATA_WIDTH-1:0]            rd_data_o,
    output logic                             rd_valid_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             overflow_o,
    output logic                             timeout_o
);

    localparam int DEPTH = N * N;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] mem      [DEPTH];
    logic [CW-1:0]         cnt      [N];
    logic [CW-1:0]         cnt_nxt  [N];
    logic [AW-1:0]         wr_addr  [N];
    logic [N-1:0]          wr_en;
    logic                  all_full;
    logic                  drop;
    logic                  clear;
    logic                  overflow_q;
    logic                  timeout_hit;

    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        drop      = 1'b0;
        all_full  = 1'b1;
        wr_en     = '0;
        for (int c = 0; c < N; c++) begin
            cnt_nxt[c] = cnt[c];
            wr_addr[c] = AW'(int'(cnt[c]) * N + c);
            if (col_valid_i[c]) begin
                if (cnt[c] == CW'(N)) begin
                    drop = drop | (state != S_IDLE);
                end else if (state == S_COLLECT) begin
                    wr_en[c]   = 1'b1;
                    cnt_nxt[c] = cnt[c] + 1'b1;
                end
            end
            if (cnt_nxt[c] != CW'(N)) begin
                all_full = 1'b0;
            end
        end

        // Completion looks ahead at this cycle's writes so simultaneous final words finish together.
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    state_nxt = S_COLLECT;
                    clear     = 1'b1;
                end
            end
            S_COLLECT: begin
                if (all_full || timeout_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start_i) begin
                    state_nxt = S_COLLECT;
                    clear     = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (clear) begin
            for (int c = 0; c < N; c++) begin
                cnt_nxt[c] = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            overflow_q <= 1'b0;
            for (int c = 0; c < N; c++) begin
                cnt[c] <= '0;
            end
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (clear) begin
                overflow_q <= 1'b0;
            end else if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; each column owns a disjoint address set so writes never collide.
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < N; c++) begin
            if (wr_en[c] && !rst_i) begin
                mem[wr_addr[c]] <= col_data_i[c];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_o  <= '0;
            rd_valid_o <= 1'b0;
        end else begin
            rd_valid_o <= rd_en_i;
            if (rd_en_i) begin
                rd_data_o <= mem[rd_addr_i];
            end
        end
    end

`ifdef SYSTOLIC_OQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt;
    logic          timeout_q;

    assign timeout_hit = (state == S_COLLECT) && (col_valid_i == '0) &&
                         (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
            if (state == S_COLLECT) begin
                idle_cnt <= (col_valid_i == '0) ? idle_cnt + 1'b1 : '0;
            end
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    assign busy_o     = (state == S_COLLECT);
    assign done_o     = (state == S_DONE);
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_systolic_output_queue.sv
// Randomized bench for systolic_output_queue (N=4) against a behavioural buffer/counter model.
module tb_systolic_output_queue;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TO = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [N-1:0][DW-1:0] col_data;
    logic [N-1:0]         col_valid;
    logic                 rd_en;
    logic [3:0]           rd_addr;
    logic [DW-1:0]        rd_data;
    logic                 rd_valid;
    logic                 busy;
    logic                 done;
    logic                 overflow;
    logic                 timeout;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: phase 0=idle, 1=collecting, 2=done.
    logic [DW-1:0] m_mem   [16];
    bit            m_known [16];
    int            m_cnt   [N];
    int            m_phase;
    int            m_idle;
    bit            m_ovf;
    bit            m_to;
    bit            m_rdv;
    bit            m_rdk;
    logic [DW-1:0] m_rdd;

    always #5 clk = ~clk;

    systolic_output_queue #(
        .N              (N),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .col_data_i  (col_data),
        .col_valid_i (col_valid),
        .rd_en_i     (rd_en),
        .rd_addr_i   (rd_addr),
        .rd_data_o   (rd_data),
        .rd_valid_o  (rd_valid),
        .busy_o      (busy),
        .done_o      (done),
        .overflow_o  (overflow),
        .timeout_o   (timeout)
    );

    task automatic model_edge();
        bit all_full;
        if (rst) begin
            m_phase = 0;
            m_idle  = 0;
            m_ovf   = 0;
            m_to    = 0;
            m_rdv   = 0;
            m_rdk   = 1;
            m_rdd   = '0;
            for (int c = 0; c < N; c++) m_cnt[c] = 0;
            for (int a = 0; a < 16; a++) m_known[a] = 0;
            return;
        end
        m_rdv = rd_en;
        if (rd_en) begin
            m_rdd = m_mem[rd_addr];
            m_rdk = m_known[rd_addr];
        end
        if (m_phase == 1) begin
            for (int c = 0; c < N; c++) begin
                if (col_valid[c]) begin
                    if (m_cnt[c] < N) begin
                        m_mem[m_cnt[c] * N + c]   = col_data[c];
                        m_known[m_cnt[c] * N + c] = 1;
                        m_cnt[c]++;
                    end else begin
                        m_ovf = 1;
                    end
                end
            end
            m_idle = (col_valid == '0) ? m_idle + 1 : 0;
            all_full = 1;
            for (int c = 0; c < N; c++) if (m_cnt[c] != N) all_full = 0;
            if (all_full) m_phase = 2;
`ifdef SYSTOLIC_OQ_TIMEOUT_EN
            if (m_idle == TO) begin
                m_to    = 1;
                m_phase = 2;
            end
`endif
        end else begin
            if (m_phase == 2) begin
                for (int c = 0; c < N; c++)
                    if (col_valid[c] && m_cnt[c] == N) m_ovf = 1;
            end
            if (start) begin
                m_phase = 1;
                m_idle  = 0;
                m_ovf   = 0;
                m_to    = 0;
                for (int c = 0; c < N; c++) m_cnt[c] = 0;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start     = 1'b0;
        col_valid = '0;
        rd_en     = 1'b0;
    endtask

    task automatic drive_row(input logic [N-1:0] v);
        col_valid = v;
        for (int c = 0; c < N; c++) col_data[c] = $urandom;
    endtask

    task automatic test_reset();
        quiet();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%0b exp=0", timeout); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%0b exp=0", rd_valid); end
        checks++; if (rd_data !== '0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    endtask

    task automatic test_idle_ignore();
        drive_row(4'hF);
        tick();
        quiet();
        tick();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL idle_no_overflow got=%0b exp=0", overflow); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL idle_state busy=%0b done=%0b exp=0/0", busy, done); end
    endtask

    task automatic test_full_rows();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_busy got=%0b exp=1", busy); end
        for (int r = 0; r < N; r++) begin
            col_valid = 4'hF;
            for (int c = 0; c < N; c++) col_data[c] = DW'(r * 16 + c);
            tick();
            checks++;
            if (done !== (r == N - 1)) begin failures++; $display("FAIL full_rows_done row=%0d got=%0b exp=%0b", r, done, r == N - 1); end
        end
        quiet();
        rd_en   = 1'b1;
        rd_addr = 4'd9;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL read9_valid got=%0b exp=1", rd_valid); end
        checks++; if (rd_data !== 32'h21) begin failures++; $display("FAIL read9_data got=%h exp=00000021", rd_data); end
    endtask

    task automatic test_skewed();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 7; t++) begin
            logic [N-1:0] v;
            for (int c = 0; c < N; c++) v[c] = (t >= c) && (t < c + N);
            drive_row(v);
            tick();
            checks++;
            if (done !== (t == 6)) begin failures++; $display("FAIL skew_done t=%0d got=%0b exp=%0b", t, done, t == 6); end
        end
        quiet();
        for (int a = 0; a < 16; a++) begin
            rd_en   = 1'b1;
            rd_addr = 4'(a);
            tick();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== m_rdd) begin
                failures++; $display("FAIL skew_read addr=%0d got=%h/%0b exp=%h/1", a, rd_data, rd_valid, m_rdd);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_overflow();
        logic [DW-1:0] old14;
        old14 = m_mem[14];
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL pre_overflow got=%0b exp=0", overflow); end
        drive_row(4'b0100);
        tick();
        quiet();
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_set got=%0b exp=1", overflow); end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL overflow_stay_done got=%0b exp=1", done); end
        rd_en   = 1'b1;
        rd_addr = 4'd14;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_data !== old14) begin failures++; $display("FAIL overflow_addr14 got=%h exp=%h", rd_data, old14); end
    endtask

    task automatic test_read_collide();
        logic [DW-1:0] old5;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL restart_clears_overflow got=%0b exp=0", overflow); end
        drive_row(4'hF);
        tick();
        old5 = m_mem[5];
        drive_row(4'hF);
        rd_en   = 1'b1;
        rd_addr = 4'd5;
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== old5) begin failures++; $display("FAIL collide_old got=%h/%0b exp=%h/1", rd_data, rd_valid, old5); end
        col_valid = '0;
        tick();
        rd_en = 1'b0;
        checks++; if (rd_data !== m_mem[5]) begin failures++; $display("FAIL collide_new got=%h exp=%h", rd_data, m_mem[5]); end
        drive_row(4'hF);
        tick();
        drive_row(4'hF);
        tick();
        quiet();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL collide_done got=%0b exp=1", done); end
    endtask

    task automatic test_reset_midway();
        start = 1'b1;
        tick();
        start = 1'b0;
        drive_row(4'hF);
        tick();
        drive_row(4'hF);
        tick();
        quiet();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midreset_state busy=%0b done=%0b exp=0/0", busy, done); end
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < N; r++) begin
            drive_row(4'hF);
            tick();
            checks++;
            if (done !== (r == N - 1)) begin failures++; $display("FAIL midreset_done row=%0d got=%0b exp=%0b", r, done, r == N - 1); end
        end
        quiet();
        for (int a = 0; a < 16; a++) begin
            rd_en   = 1'b1;
            rd_addr = 4'(a);
            tick();
            checks++;
            if (rd_data !== m_rdd) begin failures++; $display("FAIL midreset_read addr=%0d got=%h exp=%h", a, rd_data, m_rdd); end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            start     = ($urandom_range(0, 11) == 0);
            drive_row(4'($urandom) & 4'($urandom));
            rd_en     = $urandom_range(0, 1) == 1;
            rd_addr   = 4'($urandom);
            tick();
            checks++;
            if (busy !== (m_phase == 1) || done !== (m_phase == 2) || overflow !== m_ovf ||
                timeout !== m_to || rd_valid !== m_rdv) begin
                failures++;
                $display("FAIL random_status cyc=%0d got busy=%0b done=%0b ovf=%0b to=%0b rdv=%0b exp %0b %0b %0b %0b %0b",
                         i, busy, done, overflow, timeout, rd_valid,
                         m_phase == 1, m_phase == 2, m_ovf, m_to, m_rdv);
            end
            if (m_rdv && m_rdk) begin
                checks++;
                if (rd_data !== m_rdd) begin failures++; $display("FAIL random_read cyc=%0d got=%h exp=%h", i, rd_data, m_rdd); end
            end
        end
        rst = 1'b0;
        quiet();
    endtask

    task automatic test_timeout();
        rst = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        drive_row(4'hF);
        tick();
        drive_row(4'hF);
        tick();
        quiet();
        for (int i = 0; i < TO - 1; i++) tick();
        checks++; if (busy !== 1'b1 || timeout !== 1'b0) begin failures++; $display("FAIL timeout_early busy=%0b to=%0b exp=1/0", busy, timeout); end
        tick();
`ifdef SYSTOLIC_OQ_TIMEOUT_EN
        checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL timeout_flag got=%0b exp=1", timeout); end
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL timeout_done done=%0b busy=%0b exp=1/0", done, busy); end
`else
        for (int i = 0; i < 20; i++) tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL no_watchdog_busy got=%0b exp=1", busy); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL no_watchdog_flag got=%0b exp=0", timeout); end
`endif
    endtask

    initial begin
        rst       = 1'b1;
        rd_addr   = '0;
        col_data  = '0;
        quiet();
        for (int a = 0; a < 16; a++) begin
            m_mem[a]   = '0;
            m_known[a] = 0;
        end
        test_reset();
        test_idle_ignore();
        test_full_rows();
        test_skewed();
        test_overflow();
        test_read_collide();
        test_reset_midway();
        test_random();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_output_queue.md
SYSTOLIC_OUTPUT_QUEUE -- requirements
Module: systolic_output_queue

Interface
REQ-001 SHALL have parameter N, default 8, meaning systolic array dimension (columns and results per column).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning result word width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning idle-cycle limit for the optional watchdog.
REQ-004 SHALL have port clk_i, input, 1, meaning the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst_i, input, 1, meaning reset; it is synchronous and active-high.
REQ-006 SHALL have port start_i, input, 1, meaning arm collection.
REQ-007 SHALL have port col_data_i, input, N x DATA_WIDTH, meaning result words from the bottom-edge PEs.
REQ-008 SHALL have port col_valid_i, input, N, meaning per-column result valid.
REQ-009 SHALL have port rd_en_i, input, 1, meaning host read strobe.
REQ-010 SHALL have port rd_addr_i, input, $clog2(N*N), meaning host read address.
REQ-011 SHALL have port rd_data_o, output, DATA_WIDTH, meaning read data.
REQ-012 SHALL have port rd_valid_o, output, 1, meaning read data valid.
REQ-013 SHALL have port busy_o, output, 1, meaning collection in progress.
REQ-014 SHALL have port done_o, output, 1, meaning all N*N results stored.
REQ-015 SHALL have port overflow_o, output, 1, meaning sticky flag for a dropped result.
REQ-016 SHALL have port timeout_o, output, 1, meaning sticky watchdog flag.

Function
REQ-017 SHALL contain an N*N x DATA_WIDTH storage array and one counter per column, each counting 0..N.
REQ-018 SHALL implement states IDLE, COLLECT, DONE; busy_o=1 only in COLLECT, and done_o=1 only in DONE.
REQ-019 IDLE: start_i=1 SHALL move the block to COLLECT next cycle and clear all counters, overflow_o and timeout_o.
REQ-020 COLLECT: for each column c with col_valid_i[c]=1 and count[c]<N, col_data_i[c] SHALL be written at address count[c]*N+c (row-major result), and count[c] SHALL increment.
REQ-021 Valids on multiple columns in the same cycle SHALL all be accepted independently.
REQ-022 A valid on a column with count[c]==N in COLLECT or DONE SHALL drop the data and set overflow_o on the next cycle; overflow_o holds until the next start or reset.
REQ-023 COLLECT SHALL move to DONE in the cycle after all counters reach N, including when the final writes land together.
REQ-024 In COLLECT, start_i SHALL be ignored; in IDLE, col_valid_i SHALL be ignored and SHALL NOT set overflow_o.
REQ-025 DONE: start_i=1 SHALL re-enter COLLECT and apply the same clears as REQ-019; stored data is retained until overwritten.
REQ-026 Reads SHALL be allowed in every state with 1-cycle latency: rd_data_o=mem[rd_addr_i] and rd_valid_o=rd_en_i, both registered; with rd_en_i=0, rd_data_o holds its last value.
REQ-027 A read and a write to the same address in the same cycle SHALL return the old data.

Reset
REQ-028 rst_i=1 SHALL force IDLE, all counters to 0, and rd_data_o, rd_valid_o, busy_o, done_o, overflow_o and timeout_o to 0 on the next edge.
REQ-029 Reset during COLLECT SHALL abandon the collection; storage contents are not reset and are not guaranteed.

Configuration
REQ-030 With macro SYSTOLIC_OQ_TIMEOUT_EN defined, in COLLECT the block SHALL count consecutive cycles with col_valid_i==0 and reset the count on any valid.
REQ-031 When that count reaches TIMEOUT_CYCLES, the block SHALL set timeout_o and move to DONE.
REQ-032 Without SYSTOLIC_OQ_TIMEOUT_EN, there SHALL be no counter, timeout_o SHALL be tied 0, and COLLECT exits only per REQ-023.

Verification (N=4, DATA_WIDTH=32)
REQ-033 Reset, start, then four cycles with col_valid_i=4'b1111 and data row*16+col -> done_o=1 one cycle after the 4th write; reading addr 9 returns 0x21.
REQ-034 Skewed valids (column c starts c cycles late, 4 words each) -> done_o only after column 3's 4th word; all 16 addresses are correct.
REQ-035 In DONE, drive col_valid_i[2]=1 -> overflow_o=1 next cycle; the addr 14 contents are unchanged.
REQ-036 Issue rd_en_i with addr 5 in the same cycle as the write to addr 5 -> old value returned with rd_valid_o=1 one cycle later; a re-read returns the new value.
REQ-037 Assert rst_i after 2 of 4 rows, then start again and feed 4 rows -> counters restart at 0 and done_o asserts after 4 rows.
REQ-038 With SYSTOLIC_OQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, stall after 2 rows -> timeout_o=1 and DONE after 16 idle cycles; without the macro, busy_o stays 1.
